// File: rtl/dcnn_io_pkg.sv
// Shared constants, FSM states and the burst range check for the DCNN RAM stream loader.
package dcnn_io_pkg;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 16;
  localparam int MEM_DEPTH = 32768;
  localparam int SUM_W     = LEN_W + 1;

  localparam logic RAM_RD_IDLE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } state_e;

  // One extra bit so base+length past the top of the address space cannot wrap.
  function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                    input logic [LEN_W-1:0]  len);
    logic [SUM_W-1:0] end_excl;
    end_excl = SUM_W'(base) + SUM_W'(len);
    return (end_excl <= SUM_W'(MEM_DEPTH));
  endfunction
endpackage

// File: rtl/ram_stream_loader_if.sv
// Command, byte stream, RAM write bus and status signals of the stream loader.
interface ram_stream_loader_if;
  import dcnn_io_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_write_signal;
  logic              ram_read_signal;
  logic              busy;
  logic              done;
  logic              error;
  logic [LEN_W-1:0]  count;

  modport master (
    output start, base_addr, length, abort, in_data, in_valid,
    input  in_ready, ram_address, ram_data, ram_write_signal, ram_read_signal,
           busy, done, error, count
  );

  modport slave (
    input  start, base_addr, length, abort, in_data, in_valid,
    output in_ready, ram_address, ram_data, ram_write_signal, ram_read_signal,
           busy, done, error, count
  );
endinterface

// File: rtl/ram_stream_loader.sv
// Converts a valid/ready byte stream into sequential single-cycle RAM write strobes
// starting at a commanded base address; all outputs are registered.
module ram_stream_loader
  import dcnn_io_pkg::*;
(
  input  logic                 clk,
  input  logic                 RST,
  ram_stream_loader_if.slave   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;

  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      wr_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      wr_q       <= wr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    count_d    = count_q;
    in_ready_d = 1'b0;
    wr_d       = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d = '0;
          error_d = 1'b0;
          if (bus.length == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (!range_ok(bus.base_addr, bus.length)) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            addr_d     = bus.base_addr;
            rem_d      = bus.length;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        // Abort beats a same-cycle accept: the byte on the bus is left unconsumed.
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
          if (accept) begin
            wr_d       = 1'b1;
            ram_addr_d = addr_q;
            ram_data_d = bus.in_data;
            addr_d     = addr_q + ADDR_W'(1);
            rem_d      = rem_q - LEN_W'(1);
            count_d    = count_q + LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d    = ST_FLUSH;
              in_ready_d = 1'b0;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      ST_ERR:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.ram_address      = ram_addr_q;
  assign bus.ram_data         = ram_data_q;
  assign bus.ram_write_signal = wr_q;
  assign bus.ram_read_signal  = RAM_RD_IDLE;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
  assign bus.count            = count_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Table-driven bench for ram_stream_loader with a write scoreboard and reset/abort corner cases.
module tb_ram_stream_loader;
  import dcnn_io_pkg::*;

  logic clk = 1'b0;
  logic RST = 1'b0;

  ram_stream_loader_if bus ();

  ram_stream_loader dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    bit                gap;
    int                abort_at;
    bit                exp_err;
    int                exp_done;
    int                exp_writes;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  vec_t vecs[9];
  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.in_ready, bus.ram_write_signal, bus.ram_read_signal, bus.busy,
                bus.done, bus.error, bus.ram_address, bus.ram_data, bus.count});
  endfunction

  // Scoreboard: every strobe seen at the RAM's sampling edge must match the next expected write.
  always @(negedge clk) begin
    if (RST) begin
      if (bus.done) done_cnt++;
      if (bus.ram_write_signal) begin
        wr_t got;
        wr_cnt++;
        got = {bus.ram_address, bus.ram_data};
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(got), 64'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr_data", 64'(got), 64'(e));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.abort = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0;
  endtask

  task automatic issue_start(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.length = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Offers bytes until n accepts have happened; returns with the last accept edge just passed.
  task automatic feed(input logic [ADDR_W-1:0] base, input int n, input bit gap);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 200) begin
      logic [DATA_W-1:0] d;
      d = DATA_W'(8'hA1 + acc * 8'h11);
      bus.in_valid = gap ? ((cyc % 2) == 0) : 1'b1;
      bus.in_data  = d;
      if (bus.in_valid && bus.in_ready) begin
        wr_t e;
        e.addr = base + ADDR_W'(acc);
        e.data = d;
        exp_q.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (acc < n) chk("feed_timeout_accepts", 64'(acc), 64'(n));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lim;
    done_cnt = 0;
    wr_cnt   = 0;
    issue_start(v.base, v.len);
    if (v.len == '0) chk($sformatf("v%0d_done_next_cycle", idx), 64'(bus.done), 64'd1);
    if (!v.exp_err && v.len != '0) begin
      chk($sformatf("v%0d_busy_in_run", idx), 64'(bus.busy), 64'd1);
      lim = (v.abort_at > 0) ? v.abort_at : int'(v.len);
      feed(v.base, lim, v.gap);
      if (v.abort_at > 0) begin
        bus.abort = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk($sformatf("v%0d_ready_after_abort", idx), 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("v%0d_done_pulses", idx), 64'(done_cnt), 64'(v.exp_done));
    chk($sformatf("v%0d_write_count", idx), 64'(wr_cnt), 64'(v.exp_writes));
    chk($sformatf("v%0d_count", idx), 64'(bus.count), 64'(v.exp_writes));
    chk($sformatf("v%0d_error", idx), 64'(bus.error), 64'(v.exp_err));
    chk($sformatf("v%0d_busy_idle", idx), 64'(bus.busy), 64'd0);
    chk($sformatf("v%0d_queue_drained", idx), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0010, 16'd4, 1'b0, 0, 1'b0, 1, 4};
    vecs[1] = '{16'h0010, 16'd4, 1'b1, 0, 1'b0, 1, 4};
    vecs[2] = '{16'h7FFE, 16'd3, 1'b0, 0, 1'b1, 0, 0};
    vecs[3] = '{16'h7FFD, 16'd3, 1'b0, 0, 1'b0, 1, 3};
    vecs[4] = '{16'h0020, 16'd0, 1'b0, 0, 1'b0, 1, 0};
    vecs[5] = '{16'h0100, 16'd8, 1'b0, 3, 1'b0, 0, 3};
    vecs[6] = '{16'h0200, 16'd2, 1'b0, 0, 1'b0, 1, 2};
    vecs[7] = '{16'h8000, 16'd1, 1'b0, 0, 1'b1, 0, 0};
    vecs[8] = '{16'h7FFF, 16'd1, 1'b1, 0, 1'b0, 1, 1};

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", all_outs(), 64'd0);
    RST = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset asserted while a write strobe is on the port.
    issue_start(16'h0300, 16'd5);
    feed(16'h0300, 2, 1'b0);
    chk("mid_burst_strobe_high", 64'(bus.ram_write_signal), 64'd1);
    RST = 1'b0;
    #1;
    chk("async_reset_outputs_zero", all_outs(), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("held_reset_outputs_zero", all_outs(), 64'd0);
    bus.in_valid = 1'b0;
    RST = 1'b1;
    run_vec(9, '{16'h0400, 16'd3, 1'b0, 0, 1'b0, 1, 3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
